// File: rtl/tt_um_weight_unpack_if.sv
// Weight-ingest bus: load control, packed word stream and the unpacked weight array.
// master drives the stream (upstream/bench); slave is the unpack block.
interface tt_um_weight_unpack_if #(
    parameter int MAX_IN_LEN  = 16,
    parameter int MAX_OUT_LEN = 8
);
    logic                                 start;
    logic [6:0]                           ui_param;
    logic [15:0]                          ui_input;
    logic                                 in_valid;
    logic                                 in_ready;
    logic [2*MAX_IN_LEN*MAX_OUT_LEN-1:0]  uo_weights;
    logic                                 uo_done;
    logic                                 uo_err;

    modport master (
        output start, ui_param, ui_input, in_valid,
        input  in_ready, uo_weights, uo_done, uo_err
    );

    modport slave (
        input  start, ui_param, ui_input, in_valid,
        output in_ready, uo_weights, uo_done, uo_err
    );
endinterface

// File: rtl/tt_um_weight_unpack.sv
// Weight-ingest stage: unpacks a row-major stream of 16-bit words (eight 2-bit ternary
// codes each, LSB first) into the flat weight bus of the ternary MVM accelerator.
module tt_um_weight_unpack #(
    parameter int MAX_IN_LEN  = 16,
    parameter int MAX_OUT_LEN = 8
) (
    input logic                  clk,
    input logic                  rst,
    tt_um_weight_unpack_if.slave bus
);
    localparam int WB = 2 * MAX_IN_LEN * MAX_OUT_LEN;

    typedef enum logic [1:0] {IDLE, CLEAR, FILL, DONE} state_t;

    state_t        state;
    logic [6:0]    param_q;
    logic [2:0]    row_q;
    logic          word_q;
    logic          in_ready_q;
    logic          done_q;
    logic          err_q;
    logic [WB-1:0] weights_q;

    logic [3:0]    in_len_m1;
    logic [2:0]    out_len_m1;
    logic          last_word_of_row;
    logic          last_word;
    logic          word_illegal;

    // 00 -> 0, 01 -> +1, 11 -> -1; the illegal code 10 is stored as 0
    function automatic logic signed [1:0] decode_field(input logic [1:0] code);
        return (code == 2'b10) ? 2'sb00 : signed'(code);
    endfunction

    function automatic logic is_illegal(input logic [1:0] code);
        return code == 2'b10;
    endfunction

    assign in_len_m1        = param_q[6:3];
    assign out_len_m1       = param_q[2:0];
    assign last_word_of_row = (word_q == in_len_m1[3]);
    assign last_word        = last_word_of_row && (row_q == out_len_m1);

    // Only fields that land inside in_len may raise the error flag
    always_comb begin
        word_illegal = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if ((int'(word_q) * 8 + k) <= int'(in_len_m1) && is_illegal(bus.ui_input[2*k +: 2]))
                word_illegal = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            param_q    <= 7'h7F;
            row_q      <= 3'd0;
            word_q     <= 1'b0;
            in_ready_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            weights_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        param_q <= bus.ui_param;
                        err_q   <= 1'b0;
                        state   <= CLEAR;
                    end
                end
                CLEAR: begin
                    weights_q  <= '0;
                    row_q      <= 3'd0;
                    word_q     <= 1'b0;
                    in_ready_q <= 1'b1;
                    state      <= FILL;
                end
                FILL: begin
                    if (bus.in_valid) begin
                        for (int r = 0; r < MAX_OUT_LEN; r++) begin
                            for (int c = 0; c < MAX_IN_LEN; c++) begin
                                if (r == int'(row_q) && (c / 8) == int'(word_q) && c <= int'(in_len_m1))
                                    weights_q[2*(r*MAX_IN_LEN + c) +: 2] <= decode_field(bus.ui_input[2*(c%8) +: 2]);
                            end
                        end
                        if (word_illegal)
                            err_q <= 1'b1;
                        if (last_word) begin
                            in_ready_q <= 1'b0;
                            done_q     <= 1'b1;
                            state      <= DONE;
                        end else if (last_word_of_row) begin
                            word_q <= 1'b0;
                            row_q  <= row_q + 3'd1;
                        end else begin
                            word_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.uo_done    = done_q;
    assign bus.uo_err     = err_q;
    assign bus.uo_weights = weights_q;
endmodule

// File: tb/tb_tt_um_weight_unpack.sv
// Directed bench for tt_um_weight_unpack: a behavioural unpack model feeds a scoreboard
// of expected weight arrays that is popped and compared when uo_done pulses.
module tb_tt_um_weight_unpack;
    localparam int IL = 16;
    localparam int OL = 8;
    localparam int WB = 2 * IL * OL;

    typedef struct {
        logic [WB-1:0] w;
        logic          err;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   edges  = 0;
    exp_t sb[$];

    logic [WB-1:0] m_w;
    logic          m_err;
    int            m_inlen, m_wpr, m_n, m_row, m_word, m_cnt;

    always #5 clk = ~clk;

    tt_um_weight_unpack_if #(.MAX_IN_LEN(IL), .MAX_OUT_LEN(OL)) bus ();

    tt_um_weight_unpack #(.MAX_IN_LEN(IL), .MAX_OUT_LEN(OL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
        edges++;
    endtask

    task automatic chk(input string tag, input logic [WB-1:0] obs, input logic [WB-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_start(input logic [6:0] p);
        m_inlen = int'(p[6:3]) + 1;
        m_wpr   = (m_inlen + 7) / 8;
        m_n     = m_wpr * (int'(p[2:0]) + 1);
        m_w     = '0;
        m_err   = 1'b0;
        m_row   = 0;
        m_word  = 0;
        m_cnt   = 0;
    endtask

    task automatic model_word(input logic [15:0] d);
        for (int k = 0; k < 8; k++) begin
            int         c;
            logic [1:0] f;
            c = m_word * 8 + k;
            f = d[2*k +: 2];
            if (c < m_inlen) begin
                if (f == 2'b10) m_err = 1'b1;
                else m_w[2*(m_row*IL + c) +: 2] = f;
            end
        end
        m_cnt++;
        m_word++;
        if (m_word == m_wpr) begin
            m_word = 0;
            m_row++;
        end
        if (m_cnt == m_n) sb.push_back('{m_w, m_err});
    endtask

    // Start edge becomes edge 0; returns just after the CLEAR cycle (edge 1)
    task automatic do_start(input logic [6:0] p);
        bus.start    = 1'b1;
        bus.ui_param = p;
        step();
        bus.start    = 1'b0;
        bus.ui_param = 7'h00;
        model_start(p);
        edges = 0;
        step();
    endtask

    task automatic push_word(input logic [15:0] d, input int gaps);
        for (int g = 0; g < gaps; g++) begin
            bus.in_valid = 1'b0;
            bus.ui_input = 16'hAAAA;
            step();
        end
        bus.in_valid = 1'b1;
        bus.ui_input = d;
        chk("in_ready_fill", WB'(bus.in_ready), WB'(1'b1));
        step();
        model_word(d);
    endtask

    task automatic wait_done(input string tag, input int exp_edges);
        int   n;
        exp_t e;
        n = 0;
        bus.in_valid = 1'b0;
        while (bus.uo_done !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        chk({tag, "_done_edge"}, WB'(edges), WB'(exp_edges));
        chk({tag, "_ready_in_done"}, WB'(bus.in_ready), WB'(1'b0));
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_weights"}, bus.uo_weights, e.w);
            chk({tag, "_err"}, WB'(bus.uo_err), WB'(e.err));
        end else begin
            errors++;
            $error("FAIL %s_scoreboard observed=empty expected=entry", tag);
        end
    endtask

    task automatic post_done(input logic pulse_start);
        bus.start    = pulse_start;
        bus.ui_param = 7'h7F;
        step();
        bus.start    = 1'b0;
        chk("done_one_cycle", WB'(bus.uo_done), WB'(1'b0));
        chk("idle_ready", WB'(bus.in_ready), WB'(1'b0));
        if (pulse_start) begin
            step();
            chk("start_in_done_ignored", WB'(bus.in_ready), WB'(1'b0));
        end
        chk("weights_hold", bus.uo_weights, m_w);
    endtask

    initial begin
        logic done_seen;
        bus.start    = 1'b0;
        bus.ui_param = 7'h00;
        bus.ui_input = 16'h0000;
        bus.in_valid = 1'b0;
        m_w          = '0;
        rst          = 1'b1;
        step();
        step();
        chk("rst_in_ready", WB'(bus.in_ready), WB'(1'b0));
        chk("rst_done", WB'(bus.uo_done), WB'(1'b0));
        chk("rst_err", WB'(bus.uo_err), WB'(1'b0));
        chk("rst_weights", bus.uo_weights, '0);
        rst = 1'b0;
        step();

        // Full 16x8 load, in_valid held
        do_start(7'h7F);
        for (int i = 0; i < 16; i++) push_word(16'h5555, 0);
        wait_done("full", 17);
        post_done(1'b0);

        // Partial 5x3 load; discarded all-ones fields must not leak
        do_start({4'd4, 3'd2});
        for (int i = 0; i < 3; i++) push_word(16'hFFFF, 0);
        wait_done("partial", 4);
        post_done(1'b0);

        // Illegal code, then a start in the first IDLE cycle clears the flag
        do_start({4'd7, 3'd0});
        push_word(16'h0002, 0);
        wait_done("illegal", 2);
        step();
        do_start({4'd11, 3'd1});
        chk("err_cleared", WB'(bus.uo_err), WB'(1'b0));

        // Gapped 12x2 stream: valid 1,0,0,1,1,0,1
        push_word(16'h0D73, 0);
        push_word(16'hAA37, 2);
        push_word(16'h3C4D, 0);
        push_word(16'h5507, 1);
        wait_done("gapped", 8);
        post_done(1'b0);

        // Reset in the middle of FILL
        do_start(7'h7F);
        push_word(16'h5555, 0);
        push_word(16'h5555, 0);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_mid_weights", bus.uo_weights, '0);
        chk("rst_mid_ready", WB'(bus.in_ready), WB'(1'b0));
        step();
        rst = 1'b0;
        done_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.uo_done !== 1'b0) done_seen = 1'b1;
        end
        chk("rst_mid_no_done", WB'(done_seen), WB'(1'b0));
        chk("rst_mid_idle", WB'(bus.in_ready), WB'(1'b0));
        do_start(7'h7F);
        for (int i = 0; i < 16; i++) push_word(16'hFFFF, 0);
        wait_done("after_rst", 17);
        post_done(1'b0);

        // Ignored inputs: in_valid in IDLE, start in FILL and in DONE
        bus.in_valid = 1'b1;
        bus.ui_input = 16'h5555;
        step();
        step();
        bus.in_valid = 1'b0;
        chk("idle_valid_ready", WB'(bus.in_ready), WB'(1'b0));
        chk("idle_valid_weights", bus.uo_weights, m_w);
        do_start({4'd2, 3'd1});
        push_word(16'h0035, 0);
        bus.in_valid = 1'b0;
        bus.start    = 1'b1;
        bus.ui_param = 7'h7F;
        step();
        bus.start    = 1'b0;
        push_word(16'h00FD, 0);
        wait_done("ignored", 4);
        post_done(1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/tt_um_weight_unpack.md
# tt_um_weight_unpack

Upstream weight-ingest stage of the ternary matrix-vector accelerator. It accepts a stream of 16-bit words, each carrying eight 2-bit-encoded ternary weights. It unpacks them row-major into the flat signed weight bus consumed by the multiplier and output stages, sized for the configured matrix dimensions. It zero-fills unused slots, flags illegal encodings and pulses done when the matrix is complete.

## Interface
Parameters:
- MAX_IN_LEN, 16, maximum columns (inputs per output row); must be a multiple of 8
- MAX_OUT_LEN, 8, maximum rows (outputs)

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high
- start  input  1  one-cycle load request; honoured only in IDLE
- ui_param  input  7  matrix size, latched on accepted start: [6:3] = in_len-1 (1..16), [2:0] = out_len-1 (1..8)
- ui_input  input  16  packed weight word
- in_valid  input  1  ui_input holds a word
- in_ready  output  1  block accepts a word this cycle
- uo_weights  output  2*MAX_IN_LEN*MAX_OUT_LEN  weight array; weight (r,c) at bits [2*(r*MAX_IN_LEN+c) +: 2]
- uo_done  output  1  one-cycle pulse: matrix fully loaded
- uo_err  output  1  sticky: illegal encoding seen since last start

## Operation
- Encoding per 2-bit field: 00 = 0, 01 = +1, 11 = -1 (two's complement), 10 = illegal. An illegal field is stored as 00 and sets uo_err.
- Word layout: field k (bits [2k+1:2k], k=0..7) is the weight at column base+k. Fields are LSB first.
- Words per row: W = ceil(in_len/8), i.e. 1 or 2. Total words: N = W*out_len (1..16).
- Row-major order: row 0 word 0, row 0 word 1 (if W=2), row 1 word 0, and so on.
- Fields beyond in_len in the last word of a row are discarded. They are stored as 0 and never set uo_err.
- Rows at or above out_len and columns at or above in_len stay 0 for the whole load.

States:
- IDLE: in_ready=0. start=1 latches ui_param, clears uo_err and goes to CLEAR.
- CLEAR: the whole uo_weights array is zeroed in one cycle. Row and word counters reset to 0. Next state is FILL.
- FILL: in_ready=1. A word is accepted on an edge where in_valid=1. Its fields are written to the current row/word slot and the counters advance. The word counter wraps at W and increments the row. Acceptance of word N-1 moves the block to DONE.
- DONE: uo_done=1 and in_ready=0 for exactly one cycle, then IDLE.

Further rules:
- start outside IDLE is ignored. A load cannot be aborted except by rst.
- in_valid outside FILL is ignored; no word is consumed.
- uo_weights holds its contents from DONE until the next CLEAR. Downstream may read it at any time outside CLEAR/FILL.
- ui_param changes after the start cycle have no effect.

## Timing
- Reset values: state IDLE, in_ready 0, uo_done 0, uo_err 0, uo_weights all 0, counters 0, latched param 7'h7F.
- rst asserted mid-load returns the block to IDLE immediately (asynchronously). Partially written weights are cleared.
- Start accepted at edge E0 → CLEAR during cycle E0..E1 → in_ready=1 from E1.
- Word accepted at edge E: its weights are visible on uo_weights after E. uo_err rises after E if the word is illegal.
- Last word accepted at edge E: uo_done=1 for the cycle after E, and IDLE after E+1.
- Minimum load time is N+2 cycles from start, with in_valid held high.
- start asserted in the DONE cycle is ignored. start in the first IDLE cycle after DONE is accepted.

## Test plan
- Full 16x8 load: param 7'h7F, 16 words of 16'h5555 with in_valid held → all 128 weights = 2'b01. uo_done pulses exactly once, 17 cycles after the accepted start edge. uo_err=0.
- Partial 5x3 load: param {4'd4,3'd2}, 3 words of 16'hFFFF → rows 0-2 cols 0-4 = 2'b11, every other field 0. N=3. uo_err=0 even though the discarded fields are all 1.
- Illegal code: param {4'd7,3'd0}, one word 16'h0002 → weight (0,0)=00 and uo_err=1 after that edge. The next start clears uo_err.
- Gapped stream: 12x2 load (W=2, N=4) with in_valid toggling 1,0,0,1,1,0,1 → exactly 4 words accepted in order. Words with bit-pattern tags land at (r0,c0-7), (r0,c8-11), (r1,c0-7), (r1,c8-11).
- Reset mid-FILL: assert rst after 2 of 16 words → uo_weights=0, in_ready=0, uo_done never pulses. A fresh start then completes normally.
- Ignored inputs: start pulsed during FILL and in_valid pulsed during IDLE → no state or counter change, and the load completes with the original parameters.
